// File: rtl/picture_binarization_adaptive_pkg.sv
// Shared definitions for the adaptive picture binarizer.
// Holds the runtime mode encoding used by the top level when it decodes
// cfg_mode and selects the compare criterion.
package picture_binarization_adaptive_pkg;

  // Mode encoding of cfg_mode; MODE_RSVD behaves exactly like MODE_FIXED.
  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_BAND  = 2'd1,
    MODE_AUTO  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

endpackage

// File: rtl/picture_binarization_adaptive_if.sv
// Video stream bundle between the Y extraction stage, the binarizer and the
// morphology/projection stages.
//   per_frame_vsync/href/clken, per_img_Y  : incoming luma stream
//   post_frame_vsync/href/clken, post_img_Bit : outgoing 1-bit mask stream
// master = stream source/sink side (upstream + downstream), slave = binarizer.
interface picture_binarization_adaptive_if #(
  parameter int DATA_W = 8
);

  logic              per_frame_vsync;
  logic              per_frame_href;
  logic              per_frame_clken;
  logic [DATA_W-1:0] per_img_Y;
  logic              post_frame_vsync;
  logic              post_frame_href;
  logic              post_frame_clken;
  logic              post_img_Bit;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit
  );

endinterface

// File: rtl/picture_binarization_adaptive_frame_minmax_stat.sv
// Per-frame luma statistics for the adaptive binarizer.
// Tracks the running min/max of valid pixels in the current frame and, on the
// frame_start strobe, publishes them and refreshes the auto threshold with
// the rounded midrange when the frame had enough contrast.
//   clk, rst_n          : pixel clock, async active-low reset
//   frame_start         : one-cycle strobe on vsync rise
//   pix_valid, pix_y    : qualified pixel and its luma
//   auto_thr            : auto threshold currently in force
//   auto_thr_next       : value auto_thr takes at this frame_start
//   stat_frame_min/max  : min/max of the last completed non-empty frame
module picture_binarization_adaptive_frame_minmax_stat #(
  parameter int DATA_W    = 8,
  parameter int THRESHOLD = 80,
  parameter int MIN_SPAN  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_y,
  output logic [DATA_W-1:0] auto_thr,
  output logic [DATA_W-1:0] auto_thr_next,
  output logic [DATA_W-1:0] stat_frame_min,
  output logic [DATA_W-1:0] stat_frame_max
);

  localparam logic [DATA_W-1:0] ALL_ONES = '1;
  localparam logic [DATA_W-1:0] THR_INIT = DATA_W'(THRESHOLD);
  localparam logic [DATA_W:0]   SPAN_MIN = (DATA_W+1)'(MIN_SPAN);

  logic [DATA_W-1:0] run_min;
  logic [DATA_W-1:0] run_max;
  logic              seen_pix;
  logic [DATA_W:0]   mid_sum;
  logic [DATA_W-1:0] span;
  logic              span_ok;

  // Rounded midrange needs one extra bit so min+max+1 cannot wrap. The auto
  // threshold only moves when the frame had pixels and enough contrast;
  // otherwise a flat or empty frame would drag it somewhere meaningless.
  always_comb begin
    mid_sum       = {1'b0, run_min} + {1'b0, run_max} + (DATA_W+1)'(1);
    span          = run_max - run_min;
    span_ok       = seen_pix && ({1'b0, span} >= SPAN_MIN);
    auto_thr_next = span_ok ? DATA_W'(mid_sum >> 1) : auto_thr;
  end

  // Statistics state. A pixel arriving on the frame_start cycle already
  // belongs to the new frame, so it seeds the fresh min/max directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_min        <= ALL_ONES;
      run_max        <= '0;
      seen_pix       <= 1'b0;
      auto_thr       <= THR_INIT;
      stat_frame_min <= '0;
      stat_frame_max <= '0;
    end else if (frame_start) begin
      if (seen_pix) begin
        stat_frame_min <= run_min;
        stat_frame_max <= run_max;
      end
      auto_thr <= auto_thr_next;
      run_min  <= pix_valid ? pix_y : ALL_ONES;
      run_max  <= pix_valid ? pix_y : '0;
      seen_pix <= pix_valid;
    end else if (pix_valid) begin
      if (pix_y < run_min) begin
        run_min <= pix_y;
      end
      if (pix_y > run_max) begin
        run_max <= pix_y;
      end
      seen_pix <= 1'b1;
    end
  end

endmodule

// File: rtl/picture_binarization_adaptive.sv
// Adaptive luma binarizer: turns a DATA_W-bit luma stream into a 1-bit mask
// using a fixed threshold, a band window or an auto threshold derived from
// the previous frame's min/max. Configuration is shadowed at vsync rise so
// the criterion never changes inside a frame.
//   clk, rst_n          : pixel clock, async active-low reset
//   cfg_mode            : 0 fixed-below, 1 band, 2 auto, 3 as 0
//   cfg_thr_lo/hi       : fixed/lower and upper band thresholds
//   cfg_invert          : invert mask on valid pixels
//   video (slave)       : per_* stream in, post_* mask stream out (1 cycle)
//   stat_thr_active     : threshold in force for the current frame
//   stat_frame_min/max  : luma extremes of the last completed frame
module picture_binarization_adaptive
  import picture_binarization_adaptive_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int THRESHOLD = 80,
  parameter int MIN_SPAN  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [1:0]                      cfg_mode,
  input  logic [DATA_W-1:0]               cfg_thr_lo,
  input  logic [DATA_W-1:0]               cfg_thr_hi,
  input  logic                            cfg_invert,
  picture_binarization_adaptive_if.slave  video,
  output logic [DATA_W-1:0]               stat_thr_active,
  output logic [DATA_W-1:0]               stat_frame_min,
  output logic [DATA_W-1:0]               stat_frame_max
);

  localparam logic [DATA_W-1:0] THR_INIT = DATA_W'(THRESHOLD);

  logic              vsync_prev;
  logic              frame_start;
  logic              pix_valid;
  mode_e             cfg_mode_e;
  mode_e             shd_mode;
  logic [DATA_W-1:0] shd_thr_lo;
  logic [DATA_W-1:0] shd_thr_hi;
  logic              shd_invert;
  logic [DATA_W-1:0] auto_thr;
  logic [DATA_W-1:0] auto_thr_next;
  logic [DATA_W-1:0] thr_next;
  logic              raw_bit;

  assign frame_start = video.per_frame_vsync & ~vsync_prev;
  assign pix_valid   = video.per_frame_href & video.per_frame_clken;
  assign cfg_mode_e  = mode_e'(cfg_mode);

  picture_binarization_adaptive_frame_minmax_stat #(
    .DATA_W    (DATA_W),
    .THRESHOLD (THRESHOLD),
    .MIN_SPAN  (MIN_SPAN)
  ) u_stat (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (frame_start),
    .pix_valid      (pix_valid),
    .pix_y          (video.per_img_Y),
    .auto_thr       (auto_thr),
    .auto_thr_next  (auto_thr_next),
    .stat_frame_min (stat_frame_min),
    .stat_frame_max (stat_frame_max)
  );

  // Threshold reported for the frame about to start, taken from the
  // incoming cfg because that is what the shadow will hold next cycle.
  always_comb begin
    thr_next = cfg_thr_lo;
    if (cfg_mode_e == MODE_AUTO) begin
      thr_next = auto_thr_next;
    end
  end

  // Compare against the shadowed settings only; on a frame_start cycle this
  // still sees the old frame's criterion, which is intended.
  always_comb begin
    raw_bit = 1'b0;
    case (shd_mode)
      MODE_BAND: raw_bit = (shd_thr_lo <= shd_thr_hi) &&
                           (video.per_img_Y >= shd_thr_lo) &&
                           (video.per_img_Y <= shd_thr_hi);
      MODE_AUTO: raw_bit = (video.per_img_Y < auto_thr);
      default:   raw_bit = (video.per_img_Y < shd_thr_lo);
    endcase
  end

  // Shadow configuration and the reported active threshold, refreshed only
  // at frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_mode        <= MODE_FIXED;
      shd_thr_lo      <= THR_INIT;
      shd_thr_hi      <= '1;
      shd_invert      <= 1'b0;
      stat_thr_active <= THR_INIT;
    end else if (frame_start) begin
      shd_mode        <= cfg_mode_e;
      shd_thr_lo      <= cfg_thr_lo;
      shd_thr_hi      <= cfg_thr_hi;
      shd_invert      <= cfg_invert;
      stat_thr_active <= thr_next;
    end
  end

  // One-cycle sync delay and registered mask, kept together so they stay
  // aligned; invalid pixels always produce 0 regardless of invert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev             <= 1'b0;
      video.post_frame_vsync <= 1'b0;
      video.post_frame_href  <= 1'b0;
      video.post_frame_clken <= 1'b0;
      video.post_img_Bit     <= 1'b0;
    end else begin
      vsync_prev             <= video.per_frame_vsync;
      video.post_frame_vsync <= video.per_frame_vsync;
      video.post_frame_href  <= video.per_frame_href;
      video.post_frame_clken <= video.per_frame_clken;
      video.post_img_Bit     <= pix_valid ? (raw_bit ^ shd_invert) : 1'b0;
    end
  end

endmodule

// File: doc/picture_binarization_adaptive.md
Name: picture_binarization_adaptive

Overview:
- Parametrised next-generation binarizer for the video pipeline. It sits between the Y (grey) extraction stage and the morphology/projection stages.
- Converts DATA_W-bit luma to a 1-bit mask, with runtime-selectable modes: fixed threshold, band window, and auto threshold.
- Auto mode uses the midrange of the previous frame's min/max luma.
- All configuration is shadowed and applied only at frame start, so the mask never changes criteria mid-frame.

Parameters:
- DATA_W, 8, luma and threshold width (4..12).
- THRESHOLD, 80, reset value of the auto threshold and of the active threshold register.
- MIN_SPAN, 16, minimum (max-min) required before the auto threshold is updated; below this span the previous auto threshold is kept.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  async reset, active-low
- cfg_mode  in  2  0 fixed-below, 1 band, 2 auto, 3 reserved (behaves as 0)
- cfg_thr_lo  in  DATA_W  lower/fixed threshold
- cfg_thr_hi  in  DATA_W  upper band threshold
- cfg_invert  in  1  invert output mask
- per_frame_vsync  in  1  frame sync, active-high
- per_frame_href  in  1  line valid
- per_frame_clken  in  1  pixel valid
- per_img_Y  in  DATA_W  luma
- post_frame_vsync  out  1  vsync delayed 1 cycle
- post_frame_href  out  1  href delayed 1 cycle
- post_frame_clken  out  1  clken delayed 1 cycle
- post_img_Bit  out  1  mask bit
- stat_thr_active  out  DATA_W  threshold in use for the current frame (mode 0/2) or thr_lo (mode 1)
- stat_frame_min  out  DATA_W  min luma of the last completed frame
- stat_frame_max  out  DATA_W  max luma of the last completed frame

Behaviour:
- Reset (async, rst_n low) sets:
  - all post_* outputs to 0;
  - stat_frame_min to 0 and stat_frame_max to 0;
  - the auto threshold and stat_thr_active to THRESHOLD;
  - the shadow registers to mode 0, thr_lo=THRESHOLD, thr_hi=all-ones, invert=0;
  - the running min to all-ones and the running max to 0;
  - seen_pix to 0.
- Frame start event = rising edge of per_frame_vsync, detected with a registered previous vsync (reset 0). On that cycle:
  - cfg_* is latched into the shadow registers.
  - If seen_pix=1: stat_frame_min/max <= running min/max. If in addition (max-min) >= MIN_SPAN, auto_thr <= (min+max+1)>>1, computed with a DATA_W+1-bit sum.
  - If seen_pix=0 (empty frame) or the span is too small: auto_thr and stat_frame_* hold.
  - The running min/max are re-initialised to all-ones/0 and seen_pix is cleared.
  - stat_thr_active <= the new effective threshold: shadow thr_lo for mode 0/3, the updated auto_thr for mode 2, thr_lo for mode 1.
- Valid pixel = per_frame_href & per_frame_clken. On a valid pixel:
  - the running min/max are updated with per_img_Y;
  - seen_pix <= 1.
  - Statistics collection happens in all modes.
- Mask, registered, latency 1 cycle, using the shadowed configuration:
  - mode 0/3: raw = (Y < thr_lo)
  - mode 1: raw = (thr_lo <= Y <= thr_hi); if thr_lo > thr_hi, raw = 0 for every pixel
  - mode 2: raw = (Y < auto_thr)
- post_img_Bit <= valid ? (raw ^ invert) : 0.
- post_frame_vsync/href/clken are per_frame_* delayed by exactly 1 cycle, aligned with post_img_Bit.
- Simultaneous vsync rise and a valid pixel:
  - the pixel is counted into the new frame's statistics;
  - its mask uses the pre-update shadow/threshold values, because the registered compare samples the old values.
- Changes to cfg_* mid-frame have no effect until the next vsync rise.
- Reset asserted mid-frame: everything returns to reset values immediately, and the first frame after reset uses the THRESHOLD defaults.
- Boundaries: Y=0 and Y=all-ones compare correctly; thr_lo=0 in mode 0 gives an all-0 mask (all-1 with invert).

Decomposition:
- Shared package: mode encodings MODE_FIXED=0, MODE_BAND=1, MODE_AUTO=2.
- Sub-module frame_minmax_stat: running min/max, seen_pix, and the midrange/span computation, with a frame_start strobe input.
- The top level holds the shadow registers, the compare and the sync delay.

Test Plan (DATA_W=8, THRESHOLD=80, MIN_SPAN=16):
- Mode 0, thr_lo=80, ramp Y=0..255 on one line -> post_img_Bit=1 for Y 0..79 and 0 for 80..255, each 1 cycle after input; sync outputs delayed 1 cycle.
- Mode 1, lo=50, hi=60 -> 1 only for Y 50..60. Then lo=70, hi=60 -> all 0. With invert=1 -> all 1 on valid pixels, 0 while href=0.
- Mode 2, frame A pixels in 20..220 -> next frame stat_thr_active=120 and stat_frame_min/max=20/220. Frame B pixels all 100..105 (span 5) -> the following frame keeps 120.
- Empty frame (vsync toggles, no clken) after frame A -> auto_thr stays 120, stat_frame_* hold 20/220.
- Change cfg_thr_lo 80→200 mid-frame in mode 0 -> Y=150 gives 0 until the next vsync rise, then 1.
- Assert rst_n low mid-line -> all outputs 0 at once; after release, auto_thr=80 and stat_thr_active=80.
